// File: rtl/joypad_port.sv
`default_nettype none
// ============================================================================
//  Module   : joypad_port
//  Brief    : Two-port serial controller interface at $4016/$4017. A strobe
//             latch reloads two 8-bit shift registers from the live button
//             inputs; each CPU read start returns the next serial bit.
//  Revision : 1.0  initial release
// ============================================================================
module joypad_port #(
  parameter int         MASK_OPPOSING = 1,
  parameter logic [6:0] OPEN_BUS      = 7'b0100000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       ENABLE,
  input  logic       WR,
  input  logic       ADDR,
  input  logic [7:0] bus,
  input  logic [7:0] buttons1,
  input  logic [7:0] buttons2,
  output logic [7:0] DATA
);

  logic       prev_enable;   // ENABLE seen on the previous cycle
  logic       start_lock;    // ENABLE was high through reset; wait for it to fall
  logic       strobe;
  logic [7:0] sr1;
  logic [7:0] sr2;

  logic       access_start;
  logic       read_start;
  logic       write_start;
  logic [7:0] masked1;
  logic [7:0] masked2;
  logic       read_bit;

  // Remove impossible D-pad combinations (Up+Down, Left+Right) before loading.
  function automatic logic [7:0] mask_dpad(input logic [7:0] b);
    logic [7:0] m;
    m = b;
    if (MASK_OPPOSING != 0) begin
      if (b[3] && b[2]) m[3:2] = 2'b00;
      if (b[1] && b[0]) m[1:0] = 2'b00;
    end
    return m;
  endfunction

  // Decode access starts and pick the bit a read would return.
  always_comb begin
    masked1      = mask_dpad(buttons1);
    masked2      = mask_dpad(buttons2);
    access_start = ENABLE && !prev_enable && !start_lock;
    read_start   = access_start && !WR;
    write_start  = access_start && WR;
    // While strobed the register is being reloaded every cycle, so the
    // live masked A bit is what the CPU sees.
    if (strobe)
      read_bit = ADDR ? masked2[7] : masked1[7];
    else
      read_bit = ADDR ? sr2[7] : sr1[7];
  end

  // Edge detector for ENABLE, blocked after reset until ENABLE drops.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      prev_enable <= 1'b0;
      start_lock  <= ENABLE;
    end else begin
      prev_enable <= ENABLE;
      if (!ENABLE) start_lock <= 1'b0;
    end
  end

  // Strobe latch written through bit 0 of $4016.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      strobe <= 1'b0;
    end else if (write_start && !ADDR) begin
      strobe <= bus[0];
    end
  end

  // Shift registers: reload while strobed, shift in ones on reads otherwise.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sr1 <= 8'hFF;
      sr2 <= 8'hFF;
    end else if (strobe) begin
      sr1 <= masked1;
      sr2 <= masked2;
    end else if (read_start) begin
      if (ADDR) sr2 <= {sr2[6:0], 1'b1};
      else      sr1 <= {sr1[6:0], 1'b1};
    end
  end

  // Registered read data, updated only on read starts.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      DATA <= {OPEN_BUS, 1'b0};
    end else if (read_start) begin
      DATA <= {OPEN_BUS, read_bit};
    end
  end

endmodule
`default_nettype wire

// File: doc/joypad_port.md
JOYPAD_PORT -- requirements
Module: joypad_port

Interface
REQ-001 Parameter MASK_OPPOSING, default 1: when 1, opposing D-pad directions pressed together are suppressed.
REQ-002 Parameter OPEN_BUS, default 7'b0100000: value driven on DATA[7:1] during reads.
REQ-003 CLK  in  1  system clock; all state SHALL update on its rising edge.
REQ-004 RESET  in  1  reset, synchronous and active-high.
REQ-005 ENABLE  in  1  chip select for the controller register pair; may stay high for several cycles per CPU access.
REQ-006 WR  in  1  access direction: 1 = write, 0 = read; sampled with ENABLE.
REQ-007 ADDR  in  1  register select: 0 = $4016 (port 1, strobe), 1 = $4017 (port 2).
REQ-008 bus  in  8  CPU write data.
REQ-009 buttons1  in  8  port-1 pressed buttons, active-high: [7]A [6]B [5]Select [4]Start [3]Up [2]Down [1]Left [0]Right.
REQ-010 buttons2  in  8  port-2 pressed buttons, same bit order as buttons1.
REQ-011 DATA  out  8  registered read data.

Function
REQ-012 An access SHALL start on the cycle where ENABLE=1 and ENABLE was 0 on the previous cycle; held ENABLE SHALL NOT start further accesses.
REQ-013 Write start with ADDR=0: strobe register <= bus[0] at that edge; bus[7:1] SHALL be ignored.
REQ-014 Write start with ADDR=1: no state change (frame-counter register lives elsewhere).
REQ-015 Masking: with MASK_OPPOSING=1, Up&Down both set clears both, and Left&Right both set clears both, before loading; other bits pass unchanged.
REQ-016 While strobe=1, both 8-bit shift registers SHALL reload from masked buttons1/buttons2 every cycle.
REQ-017 While strobe=0, shift registers SHALL hold except on read starts.
REQ-018 Read start, ADDR=0: DATA <= {OPEN_BUS, sr1[7]} at that edge; if strobe=0, sr1 <= {sr1[6:0],1'b1} at the same edge.
REQ-019 Read start, ADDR=1: same behaviour as REQ-018 using sr2; sr1 SHALL be untouched.
REQ-020 Read during strobe=1: DATA[0] SHALL equal the live masked A bit; no shift occurs (reload wins).
REQ-021 After 8 reads of a port with strobe=0, every further read of that port SHALL return DATA[0]=1 until the next reload.
REQ-022 Strobe 1->0 transition: shift registers SHALL hold the values loaded on the last cycle strobe was 1.
REQ-023 DATA SHALL hold its value between read starts; write starts SHALL NOT change DATA.
REQ-024 Read-start latency: DATA valid 1 cycle after the ENABLE rising cycle.

Reset
REQ-025 When RESET=1 at a clock edge: strobe <= 0, sr1 <= 8'hFF, sr2 <= 8'hFF, DATA <= {OPEN_BUS,1'b0}, previous-ENABLE register <= 0.
REQ-026 RESET SHALL take priority over any simultaneous access.
REQ-027 An access whose ENABLE is already high when RESET deasserts SHALL NOT start until ENABLE falls and rises again.

Verification
REQ-028 Reset, then read $4016 -> DATA=8'h41 (sr preset to all-ones).
REQ-029 buttons1=8'b1001_0001, write bus=1 then bus=0 to $4016, 8 single-cycle reads of $4016 -> DATA[0] sequence 1,0,0,1,0,0,0,1; 9th and 10th reads -> 1.
REQ-030 After the latch in REQ-029, ENABLE held high 5 cycles on one read of $4016 -> exactly one shift; next read returns bit 6 (0).
REQ-031 strobe=1, buttons2[7] toggled between reads of $4017 -> DATA[0] follows the live A bit each read, no shift; port 1 is unaffected.
REQ-032 MASK_OPPOSING=1, buttons1=8'b0000_1111, latch -> reads 5-8 return 0,0,0,0; with MASK_OPPOSING=0 -> 1,1,1,1.
REQ-033 RESET asserted after 3 of 8 reads -> next read after reset returns 1, and DATA=8'h40 during reset.
